// File: rtl/serial_subtractor_nand.sv
// Bit-serial a - b, LSB first, one bit per clock; per-bit cell built from two-input NAND gates.
// Optional SUB_OVF_EN macro adds the registered signed-overflow output ovf.
module serial_subtractor_nand #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             borrow_q;
`ifdef SUB_OVF_EN
  logic             a_sign;
  logic             b_sign;
`endif

  logic a0, b0;
  logic n_ab, n_a, n_b, x_ab;
  logic m_x, m_xa, m_c, d;
  logic a0_n, x_n, t0, t1, bout;

  assign a0 = a_sr[0];
  assign b0 = b_sr[0];

  // x_ab = a0 ^ b0, d = x_ab ^ bin (four NANDs each)
  nand u_x0 (n_ab, a0, b0);
  nand u_x1 (n_a, a0, n_ab);
  nand u_x2 (n_b, b0, n_ab);
  nand u_x3 (x_ab, n_a, n_b);
  nand u_d0 (m_x, x_ab, bin);
  nand u_d1 (m_xa, x_ab, m_x);
  nand u_d2 (m_c, bin, m_x);
  nand u_d3 (d, m_xa, m_c);

  // bout = (~a0 & b0) | (~x_ab & bin) in NAND-NAND form
  nand u_na (a0_n, a0, a0);
  nand u_nx (x_n, x_ab, x_ab);
  nand u_t0 (t0, a0_n, b0);
  nand u_t1 (t1, x_n, bin);
  nand u_bo (bout, t0, t1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      diff_sr  <= '0;
      cnt      <= '0;
      bin      <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SUB_OVF_EN
      a_sign   <= 1'b0;
      b_sign   <= 1'b0;
      ovf      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr     <= a;
            b_sr     <= b;
            diff_sr  <= '0;
            cnt      <= '0;
            bin      <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SUB_OVF_EN
            a_sign   <= a[WIDTH-1];
            b_sign   <= b[WIDTH-1];
            ovf      <= 1'b0;
`endif
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
          diff_sr <= {d, diff_sr[WIDTH-1:1]};
          bin     <= bout;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            borrow_q <= bout;
`ifdef SUB_OVF_EN
            // d is the result sign bit on the last processed bit
            ovf      <= (a_sign != b_sign) && (d != a_sign);
`endif
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign diff       = diff_sr;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor_nand.sv
// Randomised and directed check of serial_subtractor_nand (WIDTH=8) against an arithmetic model.
module tb_serial_subtractor_nand;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  serial_subtractor_nand #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [W-1:0] ed, output logic eb, output logic eo);
    int ai, bi, sa, sb, sd;
    ai = int'(av);
    bi = int'(bv);
    ed = W'((ai - bi + 256) % 256);
    eb = (ai < bi);
    sa = (ai >= 128) ? ai - 256 : ai;
    sb = (bi >= 128) ? bi - 256 : bi;
    sd = sa - sb;
    eo = (sd > 127) || (sd < -128);
  endtask

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit inj);
    logic [W-1:0] ed;
    logic eb, eo;
    int cyc, busy_cnt, extra_done;
    model(av, bv, ed, eb, eo);
    @(negedge clk);
    start = 1'b1; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    cyc = 1;
    busy_cnt = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      start = inj && (cyc == 3 || cyc == 8);
      if (start) begin a = W'($urandom); b = W'($urandom); end
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      check("done_timeout", 0, 1);
    end else begin
      if (busy) busy_cnt++;
      check("latency", cyc, W + 1);
      check("busy_cycles", busy_cnt, W + 1);
      check("diff", diff, ed);
      check("borrow_out", borrow_out, eb);
`ifdef SUB_OVF_EN
      check("ovf", ovf, eo);
`endif
      start = inj;
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      start = 1'b0;
      check("busy_after_done", busy, 0);
      check("done_pulse_width", done, 0);
      check("diff_held", diff, ed);
      check("borrow_held", borrow_out, eb);
      if (inj) begin
        extra_done = 0;
        repeat (12) begin
          @(negedge clk);
          if (done) extra_done++;
        end
        check("ignored_start_no_done", extra_done, 0);
      end
    end
  endtask

  initial begin
    logic [W-1:0] ops_a [6];
    logic [W-1:0] ops_b [6];
    logic [W-1:0] ed;
    logic eb, eo;
    int dcnt;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow_out, 0);
`ifdef SUB_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    // reset wins over a simultaneous start
    start = 1'b1; a = 8'h12; b = 8'h34;
    @(negedge clk);
    check("rst_prio_busy", busy, 0);
    rst = 1'b0; start = 1'b0;

    do_op(8'h5A, 8'h3C, 1'b0);
    do_op(8'h00, 8'h01, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b0);
    do_op(8'h80, 8'h01, 1'b0);
    do_op(8'h7F, 8'hFF, 1'b0);
    do_op(8'h05, 8'h03, 1'b0);
    do_op(8'hC3, 8'h2D, 1'b1);

    // reset in RUN cycle 4 aborts the operation
    @(negedge clk);
    start = 1'b1; a = 8'h99; b = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow_out, 0);
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    do_op(8'h10, 8'h01, 1'b0);

    for (int i = 0; i < 20; i++) begin
      do_op(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0));
    end

    // start held high: one operation every W+2 cycles
    repeat (2) @(negedge clk);
    for (int t = 0; t < 60; t++) begin
      if (t > 0) begin
        check("b2b_done", done, (t % 10) == 9);
        if ((t % 10) == 9) begin
          model(ops_a[t / 10], ops_b[t / 10], ed, eb, eo);
          check("b2b_diff", diff, ed);
          check("b2b_borrow", borrow_out, eb);
        end
      end
      start = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      if ((t % 10) == 0) begin
        ops_a[t / 10] = a;
        ops_b[t / 10] = b;
      end
      @(negedge clk);
    end
    start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
